// File: rtl/logic_unit_pkg.sv
// Shared types and the bitwise operation evaluator for logic_unit_pipe.
package logic_unit_pkg;

  // Operation select carried on in_op / out_op.
  typedef enum logic [2:0] {
    LU_AND   = 3'd0,
    LU_OR    = 3'd1,
    LU_XOR   = 3'd2,
    LU_NAND  = 3'd3,
    LU_NOR   = 3'd4,
    LU_XNOR  = 3'd5,
    LU_NOTA  = 3'd6,
    LU_PASSB = 3'd7
  } lu_op_e;

  // Widest operand the evaluator handles; callers cast their operands to
  // this width and cast the result back down to their own width.
  localparam int LU_MAX_W = 64;

  // Bitwise evaluation; every bit position is independent, so evaluating
  // at the maximum width and truncating is exact for any narrower width.
  function automatic logic [LU_MAX_W-1:0] lu_eval(
    input lu_op_e              op,
    input logic [LU_MAX_W-1:0] a,
    input logic [LU_MAX_W-1:0] b
  );
    case (op)
      LU_AND:   lu_eval = a & b;
      LU_OR:    lu_eval = a | b;
      LU_XOR:   lu_eval = a ^ b;
      LU_NAND:  lu_eval = ~(a & b);
      LU_NOR:   lu_eval = ~(a | b);
      LU_XNOR:  lu_eval = ~(a ^ b);
      LU_NOTA:  lu_eval = ~a;
      LU_PASSB: lu_eval = b;
      default:  lu_eval = a & b;
    endcase
  endfunction

endpackage

// File: rtl/lu_fifo2.sv
// Two-entry FIFO with valid/ready on both sides. Ready and valid are
// decoded from registered occupancy only, so no combinational path runs
// from out_ready to in_ready or from in_* to out_*.
module lu_fifo2 #(
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [1:0]    occ;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          push;
  logic          pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and storage; head always holds the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ + 2'(push) - 2'(pop);
      // New beat goes straight to head when the FIFO is empty, or when the
      // only entry is leaving in the same cycle.
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        head <= in_data;
      end else if (pop && (occ == 2'd2)) begin
        head <= tail;
      end
      if (push && (occ == 2'd1) && !pop) begin
        tail <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: evaluates one of eight ops on two operands,
// buffers the result with reduction flags in a 2-entry FIFO, and counts
// completed output transfers with a saturating counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_all,
  output logic             out_any,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int PW = WIDTH + 5;

  logic [WIDTH-1:0] y_new;
  logic [PW-1:0]    payload_in;
  logic [PW-1:0]    payload_out;

  // Result and flags are computed from the live inputs and captured by the
  // FIFO on the accepting edge.
  always_comb begin
    y_new      = WIDTH'(lu_eval(lu_op_e'(in_op), LU_MAX_W'(in_a), LU_MAX_W'(in_b)));
    payload_in = {in_op, |y_new, &y_new, y_new};
  end

  lu_fifo2 #(
    .DW(PW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (payload_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (payload_out)
  );

  assign out_y   = payload_out[WIDTH-1:0];
  assign out_all = payload_out[WIDTH];
  assign out_any = payload_out[WIDTH+1];
  assign out_op  = payload_out[WIDTH+4:WIDTH+2];

  // Completed-transfer counter, held at all-ones once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != {CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: instance A (WIDTH=1) walks the full
// truth table, instance B (WIDTH=8, CNT_W=4) covers flags, stalls, ordering,
// counter saturation and asynchronous reset.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=1, CNT_W=16
  logic        a_in_valid, a_in_ready, a_in_a, a_in_b;
  logic [2:0]  a_in_op;
  logic        a_out_valid, a_out_ready, a_out_y, a_out_all, a_out_any;
  logic [2:0]  a_out_op;
  logic [15:0] a_xfer;

  // Instance B: WIDTH=8, CNT_W=4
  logic        b_in_valid, b_in_ready;
  logic [7:0]  b_in_a, b_in_b;
  logic [2:0]  b_in_op;
  logic        b_out_valid, b_out_ready, b_out_all, b_out_any;
  logic [7:0]  b_out_y;
  logic [2:0]  b_out_op;
  logic [3:0]  b_xfer;

  logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_y(a_out_y), .out_all(a_out_all), .out_any(a_out_any),
    .out_op(a_out_op), .xfer_cnt(a_xfer)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_y(b_out_y), .out_all(b_out_all), .out_any(b_out_any),
    .out_op(b_out_op), .xfer_cnt(b_xfer)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       all;
    logic       any;
    logic [2:0] op;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor A: compare each emitted beat against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra: got beat y=%0h want none", a_out_y);
      end else begin
        exp_t e;
        e = qa.pop_front();
        $display("A out: op=%0d y=%0h", a_out_op, a_out_y);
        check("a_y", 64'(a_out_y), 64'(e.y));
        check("a_all", 64'(a_out_all), 64'(e.all));
        check("a_any", 64'(a_out_any), 64'(e.any));
        check("a_op", 64'(a_out_op), 64'(e.op));
      end
    end
  end

  // Monitor B: compare each emitted beat against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra: got beat y=%0h want none", b_out_y);
      end else begin
        exp_t e;
        e = qb.pop_front();
        $display("B out: op=%0d y=%02h all=%0d any=%0d", b_out_op, b_out_y, b_out_all, b_out_any);
        check("b_y", 64'(b_out_y), 64'(e.y));
        check("b_all", 64'(b_out_all), 64'(e.all));
        check("b_any", 64'(b_out_any), 64'(e.any));
        check("b_op", 64'(b_out_op), 64'(e.op));
      end
    end
  end

  task automatic send_a(input logic a, input logic b, input logic [2:0] op, input logic y);
    int n;
    logic ok;
    n = 0;
    a_in_valid = 1'b1; a_in_a = a; a_in_b = b; a_in_op = op;
    do begin
      @(negedge clk);
      ok = a_in_ready;
      if (ok) qa.push_back('{y: 8'(y), all: y, any: y, op: op});
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin total++; bad++; $display("FAIL a_accept_timeout: got in_ready=0 want 1"); end
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [7:0] y);
    int n;
    logic ok;
    n = 0;
    b_in_valid = 1'b1; b_in_a = a; b_in_b = b; b_in_op = op;
    do begin
      @(negedge clk);
      ok = b_in_ready;
      if (ok) qb.push_back('{y: y, all: &y, any: |y, op: op});
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin total++; bad++; $display("FAIL b_accept_timeout: got in_ready=0 want 1"); end
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (qa.size() != 0) begin total++; bad++; $display("FAIL a_drain_timeout: got %0d left want 0", qa.size()); end
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (qb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (qb.size() != 0) begin total++; bad++; $display("FAIL b_drain_timeout: got %0d left want 0", qb.size()); end
    @(posedge clk); #1;
  endtask

  // Truth table per op, bit i is the result for {a,b} == i.
  logic [3:0] tt [8];
  time t0, t1;

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1010;
    a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_op = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_op = 0; b_out_ready = 1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(b_in_ready), 64'd1);
    check("rst_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_out_y", 64'(b_out_y), 64'd0);
    check("rst_flags_op", 64'({b_out_all, b_out_any, b_out_op}), 64'd0);
    check("rst_xfer_b", 64'(b_xfer), 64'd0);
    check("rst_xfer_a", 64'(a_xfer), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // WIDTH=1 truth table, one beat per cycle
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 4; i++) begin
        send_a(i[1], i[0], 3'(op), tt[op][i]);
      end
    end
    drain_a();
    check("a_xfer_32", 64'(a_xfer), 64'd32);

    // WIDTH=8 flags and one-cycle latency
    send_b(8'hF0, 8'h3C, 3'd0, 8'h30);
    check("lat_out_valid", 64'(b_out_valid), 64'd1);
    check("lat_out_y", 64'(b_out_y), 64'h30);
    send_b(8'h00, 8'h00, 3'd3, 8'hFF);
    drain_b();
    check("xfer_2", 64'(b_xfer), 64'd2);

    // Stall: two beats fill the buffer, third is refused
    b_out_ready = 1'b0;
    send_b(8'h11, 8'h22, 3'd2, 8'h33);
    send_b(8'h0F, 8'hF0, 3'd1, 8'hFF);
    b_in_valid = 1'b1; b_in_a = 8'hAA; b_in_b = 8'h55; b_in_op = 3'd4;
    @(negedge clk);
    check("full_in_ready", 64'(b_in_ready), 64'd0);
    check("hold_y_1", 64'(b_out_y), 64'h33);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_y_2", 64'(b_out_y), 64'h33);
    check("hold_op", 64'(b_out_op), 64'd2);
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    check("ready_before_pop", 64'(b_in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_pop", 64'(b_in_ready), 64'd1);
    if (b_in_ready) qb.push_back('{y: 8'h00, all: 1'b0, any: 1'b0, op: 3'd4});
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    drain_b();
    check("xfer_5", 64'(b_xfer), 64'd5);

    // Occupancy 1 with push and pop every cycle
    t0 = $time;
    send_b(8'h12, 8'h34, 3'd0, 8'h10);
    send_b(8'h12, 8'h34, 3'd5, 8'hD9);
    send_b(8'h5A, 8'h00, 3'd6, 8'hA5);
    send_b(8'h00, 8'hC3, 3'd7, 8'hC3);
    t1 = $time;
    check("stream_cycles", 64'((t1 - t0) / 10), 64'd4);
    drain_b();
    check("xfer_9", 64'(b_xfer), 64'd9);

    // Saturation: 11 more transfers, 20 total on a 4-bit counter
    for (int i = 0; i < 11; i++) begin
      send_b(8'(i + 1), 8'hFF, 3'd0, 8'(i + 1));
    end
    drain_b();
    check("xfer_sat", 64'(b_xfer), 64'd15);

    // Asynchronous reset with two entries buffered
    b_out_ready = 1'b0;
    send_b(8'h01, 8'h01, 3'd0, 8'h01);
    send_b(8'h02, 8'h02, 3'd1, 8'h02);
    check("pre_rst_valid", 64'(b_out_valid), 64'd1);
    check("pre_rst_ready", 64'(b_in_ready), 64'd0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(b_out_valid), 64'd0);
    check("arst_in_ready", 64'(b_in_ready), 64'd1);
    check("arst_xfer", 64'(b_xfer), 64'd0);
    check("arst_out_y", 64'(b_out_y), 64'd0);
    qb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    b_out_ready = 1'b1;
    send_b(8'hF0, 8'h3C, 3'd2, 8'hCC);
    drain_b();
    check("post_rst_xfer", 64'(b_xfer), 64'd1);

    check("qa_empty", 64'(qa.size()), 64'd0);
    check("qb_empty", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the single 2-input AND gate. Applies one of eight bitwise logic operations to two WIDTH-bit operands, with reduction flags and a valid/ready handshake on both sides. A 2-entry output buffer absorbs downstream stalls without combinational ready paths. A saturating transfer counter supports bring-up and bench checking. It sits between a stimulus/source block and any consumer in the logic-gates training datapath.

## Interface
- WIDTH, 8: operand and result width in bits, 1..64.
- CNT_W, 16: width of the completed-transfer counter.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select (encoding under Operation).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  bitwise result.
- out_all  out  1  AND-reduction of out_y.
- out_any  out  1  OR-reduction of out_y.
- out_op  out  3  in_op echoed with its result.
- xfer_cnt  out  CNT_W  completed output transfers, saturating.

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS B (in_a ignored).
- Accept: in_valid && in_ready at a rising edge. The result is computed combinationally from in_a/in_b/in_op and written to the buffer in the same edge. out_all/out_any/out_op are stored with it.
- Buffer: 2 entries, FIFO order. Occupancy is 0, 1 or 2.
  - in_ready = (occupancy < 2).
  - out_valid = (occupancy != 0).
  - Outputs always present the oldest entry.
- Emit: out_valid && out_ready at a rising edge pops the oldest entry and increments xfer_cnt. xfer_cnt saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1. The new entry becomes the head at the next cycle.
  - At occupancy 0: push only, since out_valid is low.
  - At occupancy 2: pop only, since in_ready is low.
- Data stability: out_y/out_all/out_any/out_op are held stable while out_valid && !out_ready.
- Inputs are ignored when in_ready is low, even if in_valid is high.

## Timing
- Latency: beat accepted at edge k gives out_valid=1 with its result after edge k (one cycle) when the buffer was empty.
- Throughput: one beat per cycle with out_ready held high.
- No combinational path from in_valid or in_* to out_*.
- No combinational path from out_ready to in_ready. in_ready depends only on registered occupancy, so in_ready rises the cycle after a pop from full.
- Reset (asynchronous assert, synchronous release on clk), all outputs:
  - occupancy = 0.
  - in_ready = 1.
  - out_valid = 0.
  - out_y = 0, out_all = 0, out_any = 0, out_op = 0.
  - xfer_cnt = 0.
- Reset mid-operation: buffered entries are discarded, and no partial transfer is counted.

## Structure
- Package logic_unit_pkg:
  - op enum lu_op_e (LU_AND..LU_PASSB, 3 bits);
  - function lu_eval(op, a, b) parameterised by width.
- Sub-module lu_fifo2: 2-entry valid/ready buffer, parametrised on payload width (WIDTH+2+3). It owns the occupancy, in_ready and out_valid logic.
- Top level holds the op evaluation, the reduction flags and xfer_cnt.

## Test plan
- WIDTH=1, out_ready=1, all 8 ops × 4 (a,b) combinations, one per cycle -> out_y matches the truth table one cycle after each accept; for op 0, (1,1) -> 1 and all others -> 0; xfer_cnt=32.
- WIDTH=8, op AND, a=8'hF0, b=8'h3C -> out_y=8'h30, out_any=1, out_all=0; op NAND with a=b=8'h00 -> out_y=8'hFF, out_all=1.
- out_ready=0, three beats offered back-to-back -> first two accepted, in_ready=0 on the third cycle, out_y held at beat 1. Raise out_ready -> beats 1, 2, 3 emitted in order, with in_ready=1 one cycle after the first pop.
- Occupancy 1 with simultaneous push and pop -> occupancy stays 1, no beat lost or duplicated, and order is preserved.
- CNT_W=4, 20 transfers -> xfer_cnt reaches 15 and holds.
- Assert rst_n low with 2 entries buffered and out_valid=1 -> out_valid=0, in_ready=1 and xfer_cnt=0 immediately, without waiting for clk.
